mac_perf_collector: RTL
=======================

Name: mac_perf_collector

Overview:
- Synthesizable on-chip counterpart of the simulation-only dataflow monitor for the MAC core.
- Sits directly downstream of MAC and consumes its control/status signals: ap_start, ap_ready, ap_done, and pp0 FSM state, block and enable signals.
- Produces one performance record per MAC transaction (latency, loop iterations, stall cycles, start-to-start interval) into a small record FIFO drained by the host/debug bus.

Parameters:
- CNT_W, 32, width of every counter and record field
- STATE_W, 13, width of MAC ap_CS_fsm (one-hot)
- FIFO_DEPTH, 8, record FIFO entries (power of 2, >=2)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- ap_start  in  1  MAC ap_start
- ap_ready  in  1  MAC ap_ready (unused for counting; stored in no record)
- ap_done  in  1  MAC ap_done (internal done)
- cur_state  in  STATE_W  MAC ap_CS_fsm
- iter_start_state  in  STATE_W  one-hot code of pp0_stage0
- iter_end_state  in  STATE_W  one-hot code of pp0_stage4
- iter_start_block  in  1  stage0 subdone block
- iter_end_block  in  1  stage4 subdone block
- iter_start_enable  in  1  ap_enable_reg_pp0_iter0
- iter_end_enable  in  1  ap_enable_reg_pp0_iter1
- finish  in  1  end-of-test; sticky once seen
- rec_valid  out  1  FIFO non-empty
- rec_ready  in  1  pop when rec_valid & rec_ready
- rec_latency  out  CNT_W  head record: done_cycle - start_cycle
- rec_iters  out  CNT_W  head record: completed iterations
- rec_stalls  out  CNT_W  head record: blocked cycles
- rec_interval  out  CNT_W  head record: cycles since previous start (0 for first)
- drop_count  out  CNT_W  records lost to full FIFO
- busy  out  1  transaction in progress
- done_all  out  1  finish seen and FSM idle

Behaviour:
- Reset values: rec_valid=0, all rec_* fields=0, drop_count=0, busy=0, done_all=0; FIFO empty; finish latch cleared; first_seen cleared.
- FSM states: IDLE, RUN, END.
  - IDLE -> RUN on ap_start & !finish_latched; that cycle is start_cycle.
  - RUN -> IDLE on ap_done, unless ap_start is also 1 and !finish_latched; then stay RUN and the next transaction starts in the same cycle (back-to-back, ap_continue=1).
  - IDLE -> END when finish_latched. END holds until reset.
  - Once finish_latched, starts are ignored. A transaction already in RUN still completes and emits its record.
- Latency counter: 0 at start_cycle, +1 each RUN cycle. On ap_done its value is rec_latency. ap_start and ap_done in the same IDLE cycle gives latency 0, and the record is pushed that cycle.
- Iteration count: +1 on each cycle where all hold during RUN (or the start cycle): cur_state==iter_end_state, iter_end_enable=1, iter_end_block=0. Full-vector equality compare.
- Stall count: +1 on each such cycle where either holds:
  - (cur_state==iter_start_state & iter_start_enable & iter_start_block)
  - (cur_state==iter_end_state & iter_end_enable & iter_end_block)
  - A cycle matching both counts once.
- Interval: free counter reset to 0 on each accepted start. rec_interval = counter value at the accepted start. The first start after reset reports 0 (first_seen flag).
- Saturation: all counters and drop_count saturate at 2^CNT_W-1, with no wrap.
- Record push: the ap_done cycle latches {latency, iters, stalls, interval} into the FIFO. The done-cycle events are included in the counts. Counters clear for the next transaction.
- FIFO: registered outputs show the head entry, so a push into an empty FIFO is visible as rec_valid the next cycle.
  - Push while full without a pop: record dropped, drop_count+1.
  - Push and pop in the same cycle while full: both succeed, no drop.
  - Pop while empty: ignored.
- busy = (state==RUN). done_all = (state==END) & no transaction pending. done_all is registered and asserts one cycle after entry to END.
- Reset mid-transaction: the in-flight transaction is discarded, FIFO contents are lost, and all outputs return to reset values on the next cycle.

Test Plan:
- Single transaction: start at cycle 10, 4 unblocked iterations (stage4 seen 4x), done at cycle 30 -> one record {latency=20, iters=4, stalls=0, interval=0}, rec_valid high from cycle 31.
- Stalls: iter_end_block=1 for 3 stage4 cycles and iter_start_block=1 for 2 stage0 cycles (one overlapping cycle not possible since states are one-hot) -> stalls=5, iters unchanged.
- Back-to-back: done and start both in cycle 30, previous start at cycle 10 -> second record has interval=20, busy stays 1 with no IDLE gap.
- Overflow: 9 transactions with FIFO_DEPTH=8 and rec_ready=0 -> 8 records held, drop_count=1. Pop one head entry while a 10th push arrives in the same cycle -> no drop, drop_count stays 1.
- Finish: finish pulsed during RUN -> current record emitted, a later ap_start is ignored, done_all=1 one cycle after entry to END.
- Reset at mid-RUN cycle 15 -> cycle 16: busy=0, rec_valid=0, drop_count=0; the next start reports interval=0.

Source files
------------

// File: rtl/mac_perf_collector.sv
// mac_perf_collector
//   Synthesizable performance collector for the MAC core. Watches the MAC
//   handshake and pipeline status signals. For every transaction it builds
//   one record {latency, iterations, stall cycles, start-to-start interval}
//   and places it in a small record FIFO that the host drains.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   ap_start/ap_done     MAC handshake; ap_ready is accepted but not used
//   cur_state            MAC ap_CS_fsm (one-hot)
//   iter_*_state         one-hot codes of pipeline stage0 / stage4
//   iter_*_block/enable  stage subdone-block and iteration-enable flags
//   finish               end of test; latched internally and sticky
//   rec_valid/rec_ready  record FIFO head handshake
//   rec_*                head record fields (zero while the FIFO is empty)
//   drop_count           records lost because the FIFO was full
//   busy, done_all       transaction in progress / finished and idle
//
// state  | meaning
// S_IDLE | waiting for an accepted ap_start
// S_RUN  | transaction in flight, counters accumulating
// S_END  | finish seen while idle; held until reset
module mac_perf_collector #(
    parameter int CNT_W      = 32,
    parameter int STATE_W    = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               finish,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [CNT_W-1:0]   rec_latency,
    output logic [CNT_W-1:0]   rec_iters,
    output logic [CNT_W-1:0]   rec_stalls,
    output logic [CNT_W-1:0]   rec_interval,
    output logic [CNT_W-1:0]   drop_count,
    output logic               busy,
    output logic               done_all
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] iters;
        logic [CNT_W-1:0] stalls;
        logic [CNT_W-1:0] interval;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    state_t            state;
    logic              finish_latched;
    logic              first_seen;
    logic [CNT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  iters_q;
    logic [CNT_W-1:0]  stalls_q;
    logic [CNT_W-1:0]  ival_q;
    logic [CNT_W-1:0]  txn_ival_q;

    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    // finish counts from the cycle it is first seen, not one cycle later
    logic fin_now;
    assign fin_now = finish | finish_latched;

    logic ev_iter, ev_stall;
    assign ev_iter  = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign ev_stall = ((cur_state == iter_start_state) & iter_start_enable & iter_start_block) |
                      ((cur_state == iter_end_state) & iter_end_enable & iter_end_block);

    logic in_run, start_idle, done_run, restart, accept, push;
    assign in_run     = (state == S_RUN);
    assign start_idle = (state == S_IDLE) & ap_start & ~fin_now;
    assign done_run   = in_run & ap_done;
    assign restart    = done_run & ap_start & ~fin_now;
    assign accept     = start_idle | restart;
    assign push       = (start_idle & ap_done) | done_run;

    // Totals include the current cycle's events; outside RUN this is the
    // start cycle, so accumulation begins from zero.
    logic [CNT_W-1:0] iters_tot, stalls_tot, ival_cur;
    assign iters_tot  = sat_inc(in_run ? iters_q  : '0, ev_iter);
    assign stalls_tot = sat_inc(in_run ? stalls_q : '0, ev_stall);
    assign ival_cur   = first_seen ? ival_q : '0;

    rec_t rec_in;
    always_comb begin
        rec_in          = '0;
        rec_in.latency  = in_run ? lat_q : '0;
        rec_in.iters    = iters_tot;
        rec_in.stalls   = stalls_tot;
        rec_in.interval = in_run ? txn_ival_q : ival_cur;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done_all       <= 1'b0;
            finish_latched <= 1'b0;
            first_seen     <= 1'b0;
            lat_q          <= '0;
            iters_q        <= '0;
            stalls_q       <= '0;
            ival_q         <= '0;
            txn_ival_q     <= '0;
        end else begin
            finish_latched <= fin_now;
            done_all       <= (state == S_END);
            // value 0 on the accepting cycle, so the register holds 1 next
            ival_q         <= accept ? CNT_W'(1) : sat_inc(ival_q, 1'b1);
            if (accept) first_seen <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (fin_now) begin
                        state <= S_END;
                    end else if (ap_start && !ap_done) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        lat_q      <= CNT_W'(1);
                        iters_q    <= iters_tot;
                        stalls_q   <= stalls_tot;
                        txn_ival_q <= ival_cur;
                    end
                end
                S_RUN: begin
                    if (ap_done) begin
                        // done-cycle events belong to the finishing record
                        lat_q    <= CNT_W'(1);
                        iters_q  <= '0;
                        stalls_q <= '0;
                        if (restart) begin
                            txn_ival_q <= ival_cur;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        lat_q    <= sat_inc(lat_q, 1'b1);
                        iters_q  <= iters_tot;
                        stalls_q <= stalls_tot;
                    end
                end
                S_END: begin
                    state <= S_END;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    rec_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_FW-1:0] count;
    logic              full, pop, do_push;

    assign full    = (count == CNT_FW'(FIFO_DEPTH));
    assign pop     = (count != '0) & rec_ready;
    // a pop frees the slot in the same cycle, so push-while-full succeeds then
    assign do_push = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= rec_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count + CNT_FW'(do_push) - CNT_FW'(pop);
            drop_count <= sat_inc(drop_count, push & ~do_push);
        end
    end

    rec_t head;
    assign head         = mem[rd_ptr];
    assign rec_valid    = (count != '0);
    assign rec_latency  = rec_valid ? head.latency  : '0;
    assign rec_iters    = rec_valid ? head.iters    : '0;
    assign rec_stalls   = rec_valid ? head.stalls   : '0;
    assign rec_interval = rec_valid ? head.interval : '0;

endmodule
